mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/pulpus_arb_pkg.sv | 7 +
 rtl/arb_timeout_cnt.sv | 19 +
 rtl/mem_port_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/pulpus_arb_pkg.sv
// pulpus_arb_pkg: shared FSM states, owner encoding and error bit indices for the memory port arbiter
package pulpus_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;
  typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;
  localparam int ERR_STRAY = 0;
  localparam int ERR_TIMEOUT = 1;
endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: response watchdog, counts enabled cycles since clear and flags when TIMEOUT is reached
module arb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic res,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = (TIMEOUT > 0) && (cnt_q == W'(TIMEOUT));
  always_comb cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (res) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction and data ports, one transaction in flight
module mem_port_arbiter
  import pulpus_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        res,
  input  logic        instr_req,
  input  logic [31:0] instr_adr,
  output logic        instr_gnt,
  output logic        instr_r_valid,
  output logic [31:0] instr_read,
  input  logic        data_req,
  input  logic [31:0] data_adr,
  input  logic        data_write_enable,
  input  logic [31:0] data_write,
  output logic        data_gnt,
  output logic        data_r_valid,
  output logic [31:0] data_read,
  output logic        mem_req,
  output logic [31:0] mem_adr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_r_valid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  err
);
  state_e state_q, state_d;
  owner_e owner_q, owner_d, last_q, last_d, winner, cur;
  logic [1:0] err_q, err_d;
  logic any_req, take, resp, tmo, done, expired;

  arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .res    (res),
    .clear  (take),
    .enable (state_q == WAIT_RVALID),
    .expired(expired)
  );

  // In IDLE the live winner drives the port; afterwards the locked owner does.
  always_comb begin
    any_req = instr_req | data_req;
    winner = (instr_req && data_req)
           ? (RR_EN ? ((last_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR) : OWN_DATA)
           : (data_req ? OWN_DATA : OWN_INSTR);
    cur = (state_q == IDLE) ? winner : owner_q;
    mem_req = !res && ((state_q == IDLE && any_req) || state_q == WAIT_GNT);
    take = mem_req && mem_gnt;
    resp = state_q == WAIT_RVALID && mem_r_valid;
    tmo = state_q == WAIT_RVALID && expired && !mem_r_valid;
    done = resp || tmo;
    owner_d = (state_q == IDLE && any_req) ? winner : owner_q;
    last_d = take ? cur : last_q;
    state_d = done ? IDLE
            : take ? WAIT_RVALID
            : (state_q == IDLE && any_req) ? WAIT_GNT
            : state_q;
    err_d = err_q;
    err_d[ERR_STRAY] = err_q[ERR_STRAY] | (mem_r_valid && state_q != WAIT_RVALID);
    err_d[ERR_TIMEOUT] = err_q[ERR_TIMEOUT] | tmo;
  end

  always_comb begin
    mem_adr = (cur == OWN_DATA) ? data_adr : instr_adr;
    mem_we = mem_req && cur == OWN_DATA && data_write_enable;
    mem_wdata = (cur == OWN_DATA) ? data_write : '0;
    instr_gnt = take && cur == OWN_INSTR;
    data_gnt = take && cur == OWN_DATA;
    instr_r_valid = !res && done && owner_q == OWN_INSTR;
    data_r_valid = !res && done && owner_q == OWN_DATA;
    instr_read = (!res && tmo && owner_q == OWN_INSTR) ? '0 : mem_rdata;
    data_read = (!res && tmo && owner_q == OWN_DATA) ? '0 : mem_rdata;
    err = err_q;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      owner_q <= OWN_INSTR;
      last_q <= OWN_INSTR;
      err_q <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      err_q <= err_d;
    end
  end
endmodule
